shift_register_univ: RTL

Parametrised universal shift register. It generalises the team's fixed 5-bit, two-direction shift register to WIDTH bits. It adds rotate, arithmetic-shift, parallel-load and clear modes, a registered serial output, and a saturating shift counter that flags when a loaded word has been fully shifted out. It is used as a serialiser/deserialiser and general data-path shifter in the same design.

---
 rtl/shift_register_univ_if.sv | 25 ++
 rtl/shift_register_univ.sv | 124 ++++++++++++
 2 files changed

// File: rtl/shift_register_univ_if.sv
// Control/data bundle for the universal shift register: the master drives the
// operation request and the slave returns the register state and status.
interface shift_register_univ_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             en;
  logic [2:0]       mode;
  logic             data_in;
  logic [WIDTH-1:0] pdata_in;
  logic [WIDTH-1:0] sreg;
  logic             sout;
  logic [CW-1:0]    shift_cnt;
  logic             drained;

  modport master (
    output en, mode, data_in, pdata_in,
    input  sreg, sout, shift_cnt, drained
  );

  modport slave (
    input  en, mode, data_in, pdata_in,
    output sreg, sout, shift_cnt, drained
  );
endinterface

// File: rtl/shift_register_univ.sv
// WIDTH-bit universal shift register: shift, rotate, arithmetic shift, load and
// clear, with a registered serial output and a saturating shift counter.
module shift_register_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                clk,
  input logic                rst,
  shift_register_univ_if.slave bus
);

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  if (WIDTH < 2) begin : g_width_check
    $error("shift_register_univ: WIDTH must be at least 2");
  end

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ASR   = 3'b101,
    MODE_LOAD  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  // Counter stops at WIDTH so drained stays asserted while shifting continues.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = cnt + CW'(1);
    end
  endfunction

  function automatic logic [WIDTH-1:0] asr1(input logic [WIDTH-1:0] val);
    logic signed [WIDTH-1:0] sval;
    sval = val;
    asr1 = sval >>> 1;
  endfunction

  logic [WIDTH-1:0] sreg_p0;
  logic             sout_p0;
  logic [CW-1:0]    cnt_p0;

  logic [WIDTH-1:0] sreg_nxt;
  logic             sout_nxt;
  logic [CW-1:0]    cnt_nxt;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(bus.mode);

  always_comb begin
    sreg_nxt = sreg_p0;
    sout_nxt = sout_p0;
    cnt_nxt  = cnt_p0;
    if (bus.en) begin
      case (mode_sel)
        MODE_HOLD: begin
          sreg_nxt = sreg_p0;
        end
        MODE_SHL: begin
          sreg_nxt = {sreg_p0[WIDTH-2:0], bus.data_in};
          sout_nxt = sreg_p0[WIDTH-1];
          cnt_nxt  = sat_inc(cnt_p0);
        end
        MODE_SHR: begin
          sreg_nxt = {bus.data_in, sreg_p0[WIDTH-1:1]};
          sout_nxt = sreg_p0[0];
          cnt_nxt  = sat_inc(cnt_p0);
        end
        MODE_ROL: begin
          sreg_nxt = {sreg_p0[WIDTH-2:0], sreg_p0[WIDTH-1]};
          sout_nxt = sreg_p0[WIDTH-1];
          cnt_nxt  = sat_inc(cnt_p0);
        end
        MODE_ROR: begin
          sreg_nxt = {sreg_p0[0], sreg_p0[WIDTH-1:1]};
          sout_nxt = sreg_p0[0];
          cnt_nxt  = sat_inc(cnt_p0);
        end
        MODE_ASR: begin
          sreg_nxt = asr1(sreg_p0);
          sout_nxt = sreg_p0[0];
          cnt_nxt  = sat_inc(cnt_p0);
        end
        MODE_LOAD: begin
          sreg_nxt = bus.pdata_in;
          cnt_nxt  = '0;
        end
        MODE_CLEAR: begin
          sreg_nxt = '0;
          sout_nxt = 1'b0;
          cnt_nxt  = '0;
        end
        default: begin
          sreg_nxt = sreg_p0;
        end
      endcase
    end
  end

  // Stage p0: architectural state
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_p0 <= RESET_VAL;
      sout_p0 <= 1'b0;
      cnt_p0  <= '0;
    end else begin
      sreg_p0 <= sreg_nxt;
      sout_p0 <= sout_nxt;
      cnt_p0  <= cnt_nxt;
    end
  end

  assign bus.sreg      = sreg_p0;
  assign bus.sout      = sout_p0;
  assign bus.shift_cnt = cnt_p0;
  assign bus.drained   = (cnt_p0 == CNT_MAX);

endmodule
